// File: rtl/op_stream_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : op_stream_alu_pkg
//  Description : Opcode encoding and the shared ALU evaluation function used
//                by the multi-channel operator stream datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package op_stream_alu_pkg;

    // Operator encoding carried on each request channel
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NOT  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Widest operand the evaluation function supports
    localparam int c_MAX_WIDTH = 64;

    // Evaluate one operation on operands zero-extended to 64 bits.
    // Returns {carry, data}; data bits at and above 'width' are forced to 0.
    // Carry is only ever set by ADD (bit 'width' of the width+1 bit sum).
    function automatic logic [c_MAX_WIDTH:0] alu_eval(
        input op_e                    op,
        input logic [c_MAX_WIDTH-1:0] a,
        input logic [c_MAX_WIDTH-1:0] b,
        input logic [5:0]             shamt,
        input int unsigned            width
    );
        logic [c_MAX_WIDTH-1:0] mask;
        logic [c_MAX_WIDTH:0]   sum;
        logic [c_MAX_WIDTH-1:0] data;
        logic                   carry;
        mask  = (width >= c_MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        sum   = {1'b0, a} + {1'b0, b};
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                data  = sum[c_MAX_WIDTH-1:0];
                carry = |(sum & ~{1'b0, mask});
            end
            OP_AND:  data = a & b;
            OP_OR:   data = a | b;
            OP_XOR:  data = a ^ b;
            OP_NOT:  data = ~a;
            OP_SHL:  data = a << shamt;
            OP_SHR:  data = a >> shamt;
            default: data = a;
        endcase
        return {carry, data & mask};
    endfunction

endpackage
`default_nettype wire

// File: rtl/op_stream_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter with a registered priority
//                pointer. The pointer moves to the channel after the winner
//                whenever a grant is issued, and holds otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_en,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_gnt_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_found;

    // Search from the pointer upward, wrapping, and take the first requester
    always_comb begin
        int k;
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_ptr_nxt = r_ptr;
        k         = 0;
        if (i_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                k = int'(r_ptr) + i;
                if (k >= NUM_CH) begin
                    k = k - NUM_CH;
                end
                if (!w_found && i_req[IDX_W'(k)]) begin
                    w_found             = 1'b1;
                    o_gnt[IDX_W'(k)]    = 1'b1;
                    o_gnt_idx           = IDX_W'(k);
                end
            end
        end
        if (w_found) begin
            w_ptr_nxt = (int'(o_gnt_idx) + 1 >= NUM_CH) ? '0 : IDX_W'(int'(o_gnt_idx) + 1);
        end
    end

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/op_stream_alu.sv
`default_nettype none
// ============================================================================
//  Module      : op_stream_alu
//  Description : NUM_CH requesters share one registered ALU through a
//                round-robin arbiter. Results are tagged with their source
//                channel and queued in a DEPTH-entry output FIFO. Grants are
//                credit-limited so in-flight work always fits in the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module op_stream_alu
    import op_stream_alu_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [NUM_CH-1:0]       req_valid_i,
    output logic [NUM_CH-1:0]       req_ready_o,
    input  logic [NUM_CH*3-1:0]     req_op_i,
    input  logic [NUM_CH*WIDTH-1:0] req_a_i,
    input  logic [NUM_CH*WIDTH-1:0] req_b_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [WIDTH-1:0]        rsp_data_o,
    output logic                    rsp_carry_o,
    output logic [IDX_W-1:0]        rsp_ch_o,
    output logic [LVL_W-1:0]        level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SH_W  = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic [IDX_W-1:0] ch;
    } entry_t;

    // ------------------------------------------------------------------
    // Credit check and arbitration
    // ------------------------------------------------------------------
    logic [LVL_W-1:0]  r_level;
    logic              r_s1_valid;
    logic              w_credit;
    logic              w_grant_en;
    logic [NUM_CH-1:0] w_gnt;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_hs;

    // Held in reset, nothing is granted; otherwise only when the op fits
    assign w_credit   = (int'(r_level) + int'(r_s1_valid)) < DEPTH;
    assign w_grant_en = enable_i & rst_ni & w_credit;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .i_req     (req_valid_i),
        .i_en      (w_grant_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // The arbiter only grants asserted requests, so any grant is a handshake
    assign req_ready_o = w_gnt;
    assign w_hs        = |(w_gnt & req_valid_i);

    // ------------------------------------------------------------------
    // Stage 1: capture the winning request
    // ------------------------------------------------------------------
    op_e              r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [IDX_W-1:0] r_s1_ch;

    // Stage-1 occupancy flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_hs;
        end
    end

    // Stage-1 payload; request fields are only looked at on the handshake
    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            r_s1_op <= op_e'(req_op_i[int'(w_gnt_idx)*3 +: 3]);
            r_s1_a  <= req_a_i[int'(w_gnt_idx)*WIDTH +: WIDTH];
            r_s1_b  <= req_b_i[int'(w_gnt_idx)*WIDTH +: WIDTH];
            r_s1_ch <= w_gnt_idx;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: evaluate and push into the FIFO
    // ------------------------------------------------------------------
    logic [c_MAX_WIDTH:0] w_res;
    entry_t               w_push_entry;

    assign w_res = alu_eval(r_s1_op,
                            c_MAX_WIDTH'(r_s1_a),
                            c_MAX_WIDTH'(r_s1_b),
                            6'(r_s1_b[SH_W-1:0]),
                            WIDTH);

    assign w_push_entry.data  = w_res[WIDTH-1:0];
    assign w_push_entry.carry = w_res[c_MAX_WIDTH];
    assign w_push_entry.ch    = r_s1_ch;

    // Result bits above WIDTH are always zero and intentionally dropped
    if (WIDTH < c_MAX_WIDTH) begin : g_res_trim
        logic w_unused_hi;
        assign w_unused_hi = |w_res[c_MAX_WIDTH-1:WIDTH];
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    entry_t           r_mem [DEPTH];
    entry_t           r_last;
    entry_t           w_head;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push      = r_s1_valid;
    assign rsp_valid_o = (r_level != '0);
    assign w_pop       = rsp_valid_o & rsp_ready_i;

    // While empty, present the most recently popped entry
    assign w_head      = rsp_valid_o ? r_mem[r_rd_ptr] : r_last;
    assign rsp_data_o  = w_head.data;
    assign rsp_carry_o = w_head.carry;
    assign rsp_ch_o    = w_head.ch;
    assign level_o     = r_level;

    // FIFO storage; contents are meaningless beyond the occupancy count
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // FIFO pointers, occupancy and held output value
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= w_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire
